// File: rtl/signed_seq_mult_ctrl.sv
// signed_seq_mult_ctrl
// Sequential 8x8 signed multiplier. Operands are converted to magnitudes,
// multiplied by an 8-step unsigned shift-add loop (LSB first), and the
// 16-bit result is negated afterwards when the operand signs differ.
module signed_seq_mult_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ABS  = 3'd1,
        MUL  = 3'd2,
        SIGN = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t      state_q;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic        sign_q;
    logic [15:0] acc_q;
    logic [2:0]  cnt_q;
    logic [15:0] product_q;
    logic        busy_q;
    logic        done_q;

    logic [7:0]  a_mag_d;
    logic [7:0]  b_mag_d;
    logic [15:0] addend_d;
    logic [15:0] acc_d;
    logic [15:0] product_d;

    // Magnitudes, shift-add step and sign-corrected result.
    // 0x80 negates to itself and is then read as unsigned 128.
    always_comb begin
        a_mag_d   = a_q[7] ? (~a_q + 8'd1) : a_q;
        b_mag_d   = b_q[7] ? (~b_q + 8'd1) : b_q;
        addend_d  = b_q[cnt_q] ? ({8'h00, a_q} << cnt_q) : '0;
        acc_d     = acc_q + addend_d;
        product_d = sign_q ? (~acc_q + 16'd1) : acc_q;
    end

    // Control FSM with registered status and result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sign_q    <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        sign_q  <= a[7] ^ b[7];
                        busy_q  <= 1'b1;
                        state_q <= ABS;
                    end
                end
                ABS: begin
                    a_q     <= a_mag_d;
                    b_q     <= b_mag_d;
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= MUL;
                end
                MUL: begin
                    acc_q <= acc_d;
                    // Counter holds at 7 on the last step so no 9th pass exists.
                    if (cnt_q == 3'd7) begin
                        state_q <= SIGN;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                SIGN: begin
                    product_q <= product_d;
                    done_q    <= 1'b1;
                    state_q   <= DONE;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule
